// File: rtl/enemy_base_sprite_engine_pkg.sv
// Shared types and constants for the enemy-base sprite engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package enemy_base_pkg;

    localparam int COORD_W = 10;   // screen / world coordinate width
    localparam int IDX_W   = 3;    // palette index and base id width
    localparam int ADDR_W  = 13;   // sprite ROM address width
    localparam int CNT_W   = 16;   // per-base frame counter, covers respawn delays up to 65535

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        EXPLODING = 2'd1,
        DEAD      = 2'd2
    } base_state_t;

    // Joystick direction codes; anything else holds position.
    localparam logic [3:0] DIR_UP    = 4'b1000;  // Y+1
    localparam logic [3:0] DIR_DOWN  = 4'b0100;  // Y-1
    localparam logic [3:0] DIR_RIGHT = 4'b0010;  // X-1
    localparam logic [3:0] DIR_LEFT  = 4'b0001;  // X+1

endpackage

// File: rtl/enemy_base_channel.sv
// One enemy base: world position, ALIVE/EXPLODING/DEAD life cycle and box hit test.
// Latency: position/state update 1 vga_clk; hit-test outputs combinational on DrawX/DrawY.
// Backpressure: none, follows frame_tick and the raster unconditionally.
// Ports: vga_clk/Reset; frame_tick, direction, hit, DrawX/DrawY in;
//        pos_x/pos_y, alive, destroyed (registered pulse), in_box, flash, dx/dy out.
module enemy_base_channel
    import enemy_base_pkg::*;
#(
    parameter int                 SPR_W          = 64,
    parameter int                 SPR_H          = 72,
    parameter int                 EXPLODE_FRAMES = 16,
    parameter int                 RESPAWN_FRAMES = 120,
    parameter logic [COORD_W-1:0] INIT_X0        = 10'd200,
    parameter logic [COORD_W-1:0] INIT_Y0        = 10'd100
) (
    input  logic               vga_clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic [3:0]         direction,
    input  logic               hit,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               alive,
    output logic               destroyed,
    output logic               in_box,
    output logic               flash,
    output logic [COORD_W-1:0] dx,
    output logic [COORD_W-1:0] dy
);

    localparam logic [CNT_W-1:0] EXPL_LAST = CNT_W'(EXPLODE_FRAMES - 1);
    localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'((RESPAWN_FRAMES > 0) ? RESPAWN_FRAMES - 1 : 0);
    localparam bit               RESPAWNS  = (RESPAWN_FRAMES > 0);

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] x_mv, y_mv;
    base_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               destroyed_q, destroyed_d;

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            x_q         <= INIT_X0;
            y_q         <= INIT_Y0;
            state_q     <= ALIVE;
            cnt_q       <= '0;
            destroyed_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            destroyed_q <= destroyed_d;
        end
    end

    always_comb begin
        // Movement applies in every state; modulo-1024 wrap is intentional.
        x_mv = x_q;
        y_mv = y_q;
        if (frame_tick) begin
            case (direction)
                DIR_UP:    y_mv = y_q + COORD_W'(1);
                DIR_DOWN:  y_mv = y_q - COORD_W'(1);
                DIR_RIGHT: x_mv = x_q - COORD_W'(1);
                DIR_LEFT:  x_mv = x_q + COORD_W'(1);
                default:   ;
            endcase
        end

        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_mv;
        y_d         = y_mv;
        destroyed_d = 1'b0;

        case (state_q)
            ALIVE: begin
                // A tick in the same cycle as the hit moves the base but is
                // not counted as an explosion frame.
                if (hit) begin
                    state_d     = EXPLODING;
                    cnt_d       = '0;
                    destroyed_d = 1'b1;
                end
            end
            EXPLODING: begin
                if (frame_tick) begin
                    if (cnt_q == EXPL_LAST) begin
                        state_d = DEAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DEAD: begin
                if (RESPAWNS && frame_tick) begin
                    if (cnt_q == RESP_LAST) begin
                        // Respawn position wins over this tick's move.
                        state_d = ALIVE;
                        cnt_d   = '0;
                        x_d     = INIT_X0;
                        y_d     = INIT_Y0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ALIVE;
                cnt_d   = '0;
            end
        endcase
    end

    // Unsigned wrap-around difference makes the box test a pair of compares.
    assign dx        = DrawX - x_q;
    assign dy        = DrawY - y_q;
    assign in_box    = (int'(dx) < SPR_W) && (int'(dy) < SPR_H) && (state_q != DEAD);
    assign flash     = (state_q == EXPLODING) && cnt_q[2];
    assign pos_x     = x_q;
    assign pos_y     = y_q;
    assign alive     = (state_q == ALIVE);
    assign destroyed = destroyed_q;

endmodule

// File: rtl/enemy_base_sprite_engine.sv
// N enemy bases sharing one sprite ROM: priority hit test, ROM addressing, palette output.
// Latency: 3 vga_clk from DrawX/DrawY/blank to pix_*; rom_addr 1 vga_clk after the pixel.
// Backpressure: none, the pipeline advances every vga_clk with the raster.
// Ports: vga_clk/Reset; frame_tick, direction, hit[N], DrawX/DrawY, blank, rom_q in;
//        rom_addr, pix_valid/pix_index/pix_id, Base_X/Base_Y (packed), alive, destroyed out.
module enemy_base_sprite_engine
    import enemy_base_pkg::*;
#(
    parameter int                         N_BASES        = 2,
    parameter int                         SPR_W          = 64,
    parameter int                         SPR_H          = 72,
    parameter logic [N_BASES*COORD_W-1:0] INIT_X         = {10'd400, 10'd200},
    parameter logic [N_BASES*COORD_W-1:0] INIT_Y         = {10'd300, 10'd100},
    parameter int                         EXPLODE_FRAMES = 16,
    parameter int                         RESPAWN_FRAMES = 120,
    parameter logic [IDX_W-1:0]           EXPLODE_IDX    = 3'd7
) (
    input  logic                         vga_clk,
    input  logic                         Reset,
    input  logic                         frame_tick,
    input  logic [3:0]                   direction,
    input  logic [N_BASES-1:0]           hit,
    input  logic [COORD_W-1:0]           DrawX,
    input  logic [COORD_W-1:0]           DrawY,
    input  logic                         blank,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [IDX_W-1:0]             rom_q,
    output logic                         pix_valid,
    output logic [IDX_W-1:0]             pix_index,
    output logic [IDX_W-1:0]             pix_id,
    output logic [N_BASES*COORD_W-1:0]   Base_X,
    output logic [N_BASES*COORD_W-1:0]   Base_Y,
    output logic [N_BASES-1:0]           alive,
    output logic [N_BASES-1:0]           destroyed
);

    logic [COORD_W-1:0] ch_x  [N_BASES];
    logic [COORD_W-1:0] ch_y  [N_BASES];
    logic [COORD_W-1:0] ch_dx [N_BASES];
    logic [COORD_W-1:0] ch_dy [N_BASES];
    logic [N_BASES-1:0] ch_in_box;
    logic [N_BASES-1:0] ch_flash;

    for (genvar g = 0; g < N_BASES; g++) begin : g_base
        enemy_base_channel #(
            .SPR_W          (SPR_W),
            .SPR_H          (SPR_H),
            .EXPLODE_FRAMES (EXPLODE_FRAMES),
            .RESPAWN_FRAMES (RESPAWN_FRAMES),
            .INIT_X0        (INIT_X[COORD_W*g +: COORD_W]),
            .INIT_Y0        (INIT_Y[COORD_W*g +: COORD_W])
        ) u_channel (
            .vga_clk    (vga_clk),
            .Reset      (Reset),
            .frame_tick (frame_tick),
            .direction  (direction),
            .hit        (hit[g]),
            .DrawX      (DrawX),
            .DrawY      (DrawY),
            .pos_x      (ch_x[g]),
            .pos_y      (ch_y[g]),
            .alive      (alive[g]),
            .destroyed  (destroyed[g]),
            .in_box     (ch_in_box[g]),
            .flash      (ch_flash[g]),
            .dx         (ch_dx[g]),
            .dy         (ch_dy[g])
        );
    end

    always_comb begin
        Base_X = '0;
        Base_Y = '0;
        for (int i = 0; i < N_BASES; i++) begin
            Base_X[COORD_W*i +: COORD_W] = ch_x[i];
            Base_Y[COORD_W*i +: COORD_W] = ch_y[i];
        end
    end

    // Stage 0: lowest-index base whose box covers the pixel owns it, even if
    // its sprite texel turns out to be transparent.
    logic               sel_found;
    logic [IDX_W-1:0]   sel_id;
    logic [COORD_W-1:0] sel_dx, sel_dy;
    logic               sel_flash;
    logic [ADDR_W-1:0]  addr_d;

    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        sel_dx    = '0;
        sel_dy    = '0;
        sel_flash = 1'b0;
        for (int i = N_BASES - 1; i >= 0; i--) begin
            if (ch_in_box[i]) begin
                sel_found = 1'b1;
                sel_id    = IDX_W'(i);
                sel_dx    = ch_dx[i];
                sel_dy    = ch_dy[i];
                sel_flash = ch_flash[i];
            end
        end
        // Out-of-box pixels park at address 0 so the ROM is never overrun.
        addr_d = '0;
        if (sel_found) begin
            addr_d = ADDR_W'(sel_dy) * ADDR_W'(SPR_W) + ADDR_W'(sel_dx);
        end
    end

    // Stage 1: ROM address issued, side information tracks it.
    logic [ADDR_W-1:0] rom_addr_q;
    logic              s1_box_q, s1_flash_q, s1_blank_q;
    logic [IDX_W-1:0]  s1_id_q;
    // Stage 2: aligned with rom_q.
    logic              s2_box_q, s2_flash_q, s2_blank_q;
    logic [IDX_W-1:0]  s2_id_q;
    // Stage 3: outputs.
    logic              pix_valid_q, pix_valid_d;
    logic [IDX_W-1:0]  pix_index_q, pix_index_d;
    logic [IDX_W-1:0]  pix_id_q, pix_id_d;

    always_comb begin
        pix_valid_d = s2_box_q && s2_blank_q && (rom_q != '0);
        pix_index_d = '0;
        pix_id_d    = '0;
        if (pix_valid_d) begin
            pix_index_d = s2_flash_q ? EXPLODE_IDX : rom_q;
            pix_id_d    = s2_id_q;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            rom_addr_q  <= '0;
            s1_box_q    <= 1'b0;
            s1_flash_q  <= 1'b0;
            s1_blank_q  <= 1'b0;
            s1_id_q     <= '0;
            s2_box_q    <= 1'b0;
            s2_flash_q  <= 1'b0;
            s2_blank_q  <= 1'b0;
            s2_id_q     <= '0;
            pix_valid_q <= 1'b0;
            pix_index_q <= '0;
            pix_id_q    <= '0;
        end else begin
            rom_addr_q  <= addr_d;
            s1_box_q    <= sel_found;
            s1_flash_q  <= sel_flash;
            s1_blank_q  <= blank;
            s1_id_q     <= sel_id;
            s2_box_q    <= s1_box_q;
            s2_flash_q  <= s1_flash_q;
            s2_blank_q  <= s1_blank_q;
            s2_id_q     <= s1_id_q;
            pix_valid_q <= pix_valid_d;
            pix_index_q <= pix_index_d;
            pix_id_q    <= pix_id_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pix_valid = pix_valid_q;
    assign pix_index = pix_index_q;
    assign pix_id    = pix_id_q;

endmodule

// File: tb/tb_enemy_base_sprite_engine.sv
// Self-checking bench for enemy_base_sprite_engine with the default two-base configuration.
// Latency: reference model predicts rom_addr one cycle and pix_* three cycles after each pixel.
// Backpressure: none.
module tb_enemy_base_sprite_engine;

    localparam int NB = 2;
    localparam int SW = 64;
    localparam int SH = 72;
    localparam int EF = 16;
    localparam int RF = 120;
    localparam int IX [NB] = '{200, 400};
    localparam int IY [NB] = '{100, 300};

    logic        vga_clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic [3:0]  direction = 4'b0000;
    logic [1:0]  hit = 2'b00;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic        blank = 1'b0;
    logic [12:0] rom_addr;
    logic [2:0]  rom_q = 3'd0;
    logic        pix_valid;
    logic [2:0]  pix_index, pix_id;
    logic [19:0] Base_X, Base_Y;
    logic [1:0]  alive, destroyed;

    always #5 vga_clk = ~vga_clk;

    enemy_base_sprite_engine dut (
        .vga_clk    (vga_clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .direction  (direction),
        .hit        (hit),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .pix_valid  (pix_valid),
        .pix_index  (pix_index),
        .pix_id     (pix_id),
        .Base_X     (Base_X),
        .Base_Y     (Base_Y),
        .alive      (alive),
        .destroyed  (destroyed)
    );

    // Sprite ROM: one-cycle registered read.
    logic [2:0] mem [0:SW*SH-1];
    always @(posedge vga_clk) rom_q <= mem[rom_addr];

    // Reference model: positions, life state (0 alive, 1 exploding, 2 dead), frame counts.
    int mx [NB], my [NB], mst [NB], mcnt [NB];
    // Expected DUT outputs after the most recent clock edge.
    logic [19:0] e_bx, e_by;
    logic [1:0]  e_alive, e_dest;
    logic [12:0] e_addr;
    logic        e_pv;
    logic [2:0]  e_pi, e_pid;
    // Pixel results in flight, [0] newest.
    logic        qv [3];
    logic [2:0]  qi [3], qd [3];

    int errors = 0;
    int checks = 0;

    logic [19:0] init_bx = {10'd400, 10'd200};
    logic [19:0] init_by = {10'd300, 10'd100};

    task automatic cycle(input bit rst, input bit tk, input logic [3:0] dir,
                         input logic [1:0] h, input int px, input int py, input bit bl);
        int found, addr, ax, ay;
        bit fl, v;
        logic [2:0] idx;
        logic [1:0] dest;
        Reset = rst; frame_tick = tk; direction = dir; hit = h;
        DrawX = 10'(px); DrawY = 10'(py); blank = bl;
        // Which base owns this pixel, judged from the state before the edge.
        found = -1; addr = 0; fl = 1'b0;
        for (int i = 0; i < NB; i++) begin
            ax = (px - mx[i]) & 1023;
            ay = (py - my[i]) & 1023;
            if (found < 0 && mst[i] != 2 && ax < SW && ay < SH) begin
                found = i;
                addr  = ay * SW + ax;
                fl    = (mst[i] == 1) && ((mcnt[i] / 4) % 2 == 1);
            end
        end
        v   = (found >= 0) && bl && (mem[addr] != 3'd0);
        idx = !v ? 3'd0 : (fl ? 3'd7 : mem[addr]);
        // Life-cycle and movement rules.
        dest = 2'b00;
        for (int i = 0; i < NB; i++) begin
            if (rst) begin
                mx[i] = IX[i]; my[i] = IY[i]; mst[i] = 0; mcnt[i] = 0;
            end else begin
                dest[i] = (mst[i] == 0) && h[i];
                if (tk) begin
                    if (dir == 4'b1000) my[i] = (my[i] + 1) & 1023;
                    else if (dir == 4'b0100) my[i] = (my[i] + 1023) & 1023;
                    else if (dir == 4'b0010) mx[i] = (mx[i] + 1023) & 1023;
                    else if (dir == 4'b0001) mx[i] = (mx[i] + 1) & 1023;
                end
                if (mst[i] == 0 && h[i]) begin
                    mst[i] = 1; mcnt[i] = 0;
                end else if (mst[i] == 1 && tk) begin
                    mcnt[i]++;
                    if (mcnt[i] == EF) begin mst[i] = 2; mcnt[i] = 0; end
                end else if (mst[i] == 2 && tk && RF > 0) begin
                    mcnt[i]++;
                    if (mcnt[i] == RF) begin
                        mst[i] = 0; mcnt[i] = 0; mx[i] = IX[i]; my[i] = IY[i];
                    end
                end
            end
        end
        @(posedge vga_clk);
        #1;
        e_addr = (rst || found < 0) ? 13'd0 : 13'(addr);
        qv[2] = qv[1]; qi[2] = qi[1]; qd[2] = qd[1];
        qv[1] = qv[0]; qi[1] = qi[0]; qd[1] = qd[0];
        qv[0] = v;     qi[0] = idx;   qd[0] = v ? 3'(found) : 3'd0;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin qv[k] = 1'b0; qi[k] = 3'd0; qd[k] = 3'd0; end
        end
        e_pv = qv[2]; e_pi = qi[2]; e_pid = qd[2];
        e_dest = dest;
        for (int i = 0; i < NB; i++) begin
            e_bx[10*i +: 10] = 10'(mx[i]);
            e_by[10*i +: 10] = 10'(my[i]);
            e_alive[i] = (mst[i] == 0);
        end
    endtask

    task automatic test_reset;
        cycle(1, 0, 4'b0000, 2'b00, 0, 0, 0);
        cycle(1, 0, 4'b0000, 2'b00, 0, 0, 0);
        checks++; if (Base_X !== init_bx) begin errors++; $display("FAIL reset_base_x: got %0h expected %0h", Base_X, init_bx); end
        checks++; if (Base_Y !== init_by) begin errors++; $display("FAIL reset_base_y: got %0h expected %0h", Base_Y, init_by); end
        checks++; if (alive !== 2'b11) begin errors++; $display("FAIL reset_alive: got %0b expected 11", alive); end
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid: got %0b expected 0", pix_valid); end
        checks++; if (destroyed !== 2'b00) begin errors++; $display("FAIL reset_destroyed: got %0b expected 00", destroyed); end
        checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
    endtask

    task automatic test_move;
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, 4'b0001, 2'b00, 0, 0, 0);
            cycle(0, 0, 4'b0001, 2'b00, 0, 0, 0);
        end
        checks++; if (Base_X[9:0] !== 10'd205) begin errors++; $display("FAIL move_left_x: got %0d expected 205", Base_X[9:0]); end
        checks++; if (Base_Y[9:0] !== 10'd100) begin errors++; $display("FAIL move_left_y: got %0d expected 100", Base_Y[9:0]); end
        checks++; if (Base_X[19:10] !== 10'd405) begin errors++; $display("FAIL move_left_x1: got %0d expected 405", Base_X[19:10]); end
        for (int k = 0; k < 3; k++) cycle(0, 1, 4'b0000, 2'b00, 0, 0, 0);
        cycle(0, 1, 4'b1100, 2'b00, 0, 0, 0);
        checks++; if (Base_X !== e_bx || Base_X[9:0] !== 10'd205) begin errors++; $display("FAIL move_hold_x: got %0h expected %0h", Base_X, e_bx); end
        checks++; if (Base_Y !== e_by) begin errors++; $display("FAIL move_hold_y: got %0h expected %0h", Base_Y, e_by); end
        for (int k = 0; k < 101; k++) cycle(0, 1, 4'b0100, 2'b00, 0, 0, 0);
        checks++; if (Base_Y[9:0] !== 10'd1023) begin errors++; $display("FAIL move_down_wrap: got %0d expected 1023", Base_Y[9:0]); end
        cycle(0, 1, 4'b1000, 2'b00, 0, 0, 0);
        checks++; if (Base_Y[9:0] !== 10'd0) begin errors++; $display("FAIL move_up_wrap: got %0d expected 0", Base_Y[9:0]); end
        checks++; if (Base_Y !== e_by) begin errors++; $display("FAIL move_model_y: got %0h expected %0h", Base_Y, e_by); end
    endtask

    task automatic test_pixel;
        int b, px, py;
        cycle(1, 0, 4'b0000, 2'b00, 0, 0, 0);
        mem[650] = 3'd5;
        mem[651] = 3'd0;
        cycle(0, 0, 4'b0000, 2'b00, 210, 110, 1);
        checks++; if (rom_addr !== 13'd650) begin errors++; $display("FAIL pixel_rom_addr: got %0d expected 650", rom_addr); end
        cycle(0, 0, 4'b0000, 2'b00, 211, 110, 1);
        checks++; if (rom_addr !== 13'd651) begin errors++; $display("FAIL pixel_rom_addr_next: got %0d expected 651", rom_addr); end
        cycle(0, 0, 4'b0000, 2'b00, 0, 0, 0);
        checks++; if (pix_valid !== 1'b1 || pix_index !== 3'd5 || pix_id !== 3'd0) begin errors++;
            $display("FAIL pixel_opaque: got v=%0b i=%0d id=%0d expected v=1 i=5 id=0", pix_valid, pix_index, pix_id); end
        cycle(0, 0, 4'b0000, 2'b00, 0, 0, 0);
        checks++; if (pix_valid !== 1'b0 || pix_index !== 3'd0) begin errors++;
            $display("FAIL pixel_transparent: got v=%0b i=%0d expected v=0 i=0", pix_valid, pix_index); end
        for (int k = 0; k < 400; k++) begin
            b  = $urandom_range(0, NB - 1);
            px = mx[b] + $urandom_range(0, 79) - 8;
            py = my[b] + $urandom_range(0, 87) - 8;
            cycle(0, ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)), 2'b00, px, py, ($urandom_range(0, 3) != 0));
            checks++; if (rom_addr !== e_addr) begin errors++; $display("FAIL pixel_rand_addr: got %0d expected %0d", rom_addr, e_addr); end
            checks++; if (pix_valid !== e_pv || pix_index !== e_pi || pix_id !== e_pid) begin errors++;
                $display("FAIL pixel_rand_out: got v=%0b i=%0d id=%0d expected v=%0b i=%0d id=%0d", pix_valid, pix_index, pix_id, e_pv, e_pi, e_pid); end
        end
    endtask

    task automatic test_overlap_explode;
        int n;
        cycle(1, 0, 4'b0000, 2'b00, 0, 0, 0);
        mem[650] = 3'd5;
        // Base 1 keeps dying and respawning at its start point while base 0 walks onto it.
        for (int k = 0; k < 400; k++) cycle(0, 1, (k < 200) ? 4'b0001 : 4'b1000, 2'b10, 0, 0, 0);
        n = 0;
        while (alive[1] !== 1'b1 && n < 300) begin cycle(0, 1, 4'b0000, 2'b00, 0, 0, 0); n++; end
        checks++; if (alive !== 2'b11) begin errors++; $display("FAIL overlap_alive: got %0b expected 11", alive); end
        checks++; if (Base_X !== {10'd400, 10'd400} || Base_Y !== {10'd300, 10'd300}) begin errors++;
            $display("FAIL overlap_pos: got x=%0h y=%0h expected both at 400,300", Base_X, Base_Y); end
        cycle(0, 0, 4'b0000, 2'b00, 410, 310, 1);
        cycle(0, 0, 4'b0000, 2'b00, 0, 0, 0);
        cycle(0, 0, 4'b0000, 2'b00, 0, 0, 0);
        checks++; if (pix_valid !== 1'b1 || pix_id !== 3'd0) begin errors++; $display("FAIL overlap_prio: got v=%0b id=%0d expected v=1 id=0", pix_valid, pix_id); end
        cycle(0, 0, 4'b0000, 2'b01, 0, 0, 0);
        checks++; if (destroyed !== 2'b01) begin errors++; $display("FAIL destroyed_pulse: got %0b expected 01", destroyed); end
        cycle(0, 0, 4'b0000, 2'b01, 0, 0, 0);
        checks++; if (destroyed !== 2'b00) begin errors++; $display("FAIL destroyed_one_cycle: got %0b expected 00", destroyed); end
        cycle(0, 0, 4'b0000, 2'b00, 0, 0, 0);
        checks++; if (destroyed !== 2'b00 || alive[0] !== 1'b0) begin errors++; $display("FAIL rehit_explode: got d=%0b a=%0b expected d=00 a=0", destroyed, alive[0]); end
        for (int k = 0; k < EF; k++) begin
            cycle(0, 0, 4'b0000, 2'b00, 410, 310, 1);
            cycle(0, 0, 4'b0000, 2'b00, 0, 0, 0);
            cycle(0, 0, 4'b0000, 2'b00, 0, 0, 0);
            checks++; if (pix_valid !== 1'b1 || pix_id !== 3'd0 || pix_index !== (((k % 8) >= 4) ? 3'd7 : 3'd5)) begin errors++;
                $display("FAIL explode_flash frame %0d: got v=%0b i=%0d id=%0d expected v=1 i=%0d id=0", k, pix_valid, pix_index, pix_id, ((k % 8) >= 4) ? 7 : 5); end
            cycle(0, 1, 4'b0000, 2'b00, 0, 0, 0);
        end
        cycle(0, 0, 4'b0000, 2'b00, 410, 310, 1);
        cycle(0, 0, 4'b0000, 2'b00, 0, 0, 0);
        cycle(0, 0, 4'b0000, 2'b00, 0, 0, 0);
        checks++; if (pix_valid !== 1'b1 || pix_id !== 3'd1 || pix_index !== 3'd5) begin errors++;
            $display("FAIL dead_prio: got v=%0b i=%0d id=%0d expected v=1 i=5 id=1", pix_valid, pix_index, pix_id); end
        for (int k = 0; k < RF - 1; k++) cycle(0, 1, 4'b0000, 2'b00, 0, 0, 0);
        checks++; if (alive[0] !== 1'b0) begin errors++; $display("FAIL respawn_early: got %0b expected 0", alive[0]); end
        cycle(0, 1, 4'b0000, 2'b00, 0, 0, 0);
        checks++; if (alive[0] !== 1'b1 || Base_X[9:0] !== 10'd200 || Base_Y[9:0] !== 10'd100) begin errors++;
            $display("FAIL respawn: got a=%0b x=%0d y=%0d expected a=1 x=200 y=100", alive[0], Base_X[9:0], Base_Y[9:0]); end
    endtask

    task automatic test_hit_tick;
        cycle(1, 0, 4'b0000, 2'b00, 0, 0, 0);
        mem[325] = 3'd3;
        mem[650] = 3'd5;
        cycle(0, 1, 4'b0010, 2'b10, 0, 0, 0);
        checks++; if (Base_X[19:10] !== 10'd399 || Base_X[9:0] !== 10'd199) begin errors++;
            $display("FAIL hit_tick_pos: got %0d,%0d expected 199,399", Base_X[9:0], Base_X[19:10]); end
        checks++; if (alive !== 2'b01 || destroyed !== 2'b10) begin errors++;
            $display("FAIL hit_tick_state: got a=%0b d=%0b expected a=01 d=10", alive, destroyed); end
        for (int k = 0; k < 3; k++) cycle(0, 1, 4'b0000, 2'b00, 0, 0, 0);
        cycle(0, 0, 4'b0000, 2'b00, 404, 305, 1);
        cycle(0, 0, 4'b0000, 2'b00, 0, 0, 0);
        cycle(0, 0, 4'b0000, 2'b00, 0, 0, 0);
        checks++; if (pix_index !== 3'd3 || pix_id !== 3'd1) begin errors++; $display("FAIL hit_tick_cnt3: got i=%0d id=%0d expected i=3 id=1", pix_index, pix_id); end
        cycle(0, 1, 4'b0000, 2'b00, 404, 305, 1);
        cycle(0, 0, 4'b0000, 2'b00, 404, 305, 1);
        cycle(0, 0, 4'b0000, 2'b00, 209, 110, 1);
        cycle(0, 0, 4'b0000, 2'b00, 209, 110, 1);
        checks++; if (pix_index !== 3'd7) begin errors++; $display("FAIL hit_tick_cnt4: got %0d expected 7", pix_index); end
        cycle(1, 0, 4'b0000, 2'b00, 209, 110, 1);
        checks++; if (alive !== 2'b11 || Base_X !== init_bx || Base_Y !== init_by) begin errors++;
            $display("FAIL mid_reset_state: got a=%0b x=%0h y=%0h expected a=11 at init", alive, Base_X, Base_Y); end
        for (int j = 0; j < 4; j++) begin
            checks++; if (pix_valid !== ((j < 3) ? 1'b0 : 1'b1)) begin errors++;
                $display("FAIL mid_reset_flush %0d: got %0b expected %0b", j, pix_valid, (j < 3) ? 1'b0 : 1'b1); end
            cycle(0, 0, 4'b0000, 2'b00, 210, 110, 1);
        end
    endtask

    task automatic test_random;
        int b;
        for (int k = 0; k < 1500; k++) begin
            b = $urandom_range(0, NB - 1);
            cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0), 4'(1 << $urandom_range(0, 4)),
                  ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  mx[b] + $urandom_range(0, 79) - 8, my[b] + $urandom_range(0, 87) - 8, ($urandom_range(0, 4) != 0));
            checks++; if (rom_addr !== e_addr) begin errors++; $display("FAIL rand_addr: got %0d expected %0d", rom_addr, e_addr); end
            checks++; if (pix_valid !== e_pv || pix_index !== e_pi || pix_id !== e_pid) begin errors++;
                $display("FAIL rand_pix: got v=%0b i=%0d id=%0d expected v=%0b i=%0d id=%0d", pix_valid, pix_index, pix_id, e_pv, e_pi, e_pid); end
            checks++; if (Base_X !== e_bx || Base_Y !== e_by) begin errors++;
                $display("FAIL rand_pos: got x=%0h y=%0h expected x=%0h y=%0h", Base_X, Base_Y, e_bx, e_by); end
            checks++; if (alive !== e_alive || destroyed !== e_dest) begin errors++;
                $display("FAIL rand_state: got a=%0b d=%0b expected a=%0b d=%0b", alive, destroyed, e_alive, e_dest); end
        end
    endtask

    initial begin
        for (int i = 0; i < SW * SH; i++) mem[i] = 3'($urandom_range(0, 7));
        for (int k = 0; k < 3; k++) begin qv[k] = 1'b0; qi[k] = 3'd0; qd[k] = 3'd0; end
        for (int i = 0; i < NB; i++) begin mx[i] = IX[i]; my[i] = IY[i]; mst[i] = 0; mcnt[i] = 0; end
        test_reset();
        test_move();
        test_pixel();
        test_overlap_explode();
        test_hit_tick();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
